// File: rtl/regfile_arb_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : regfile_arb_pkg
// Description : Shared definitions for the register-file access arbiter:
//               default address/data widths, the controller state
//               enumeration and a small state-decode helper.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_arb_pkg;

    localparam int ADDR_W_DEFAULT = 6;
    localparam int DATA_W_DEFAULT = 32;

    // Controller states. INIT clears the register file, IDLE arbitrates,
    // WR/RD each issue one access, CAP picks up the read operands.
    typedef enum logic [2:0] {
        INIT = 3'd0,
        IDLE = 3'd1,
        WR   = 3'd2,
        RD   = 3'd3,
        CAP  = 3'd4
    } state_t;

    // The controller is busy in every state except IDLE.
    function automatic logic is_busy(input state_t s);
        return (s != IDLE);
    endfunction

endpackage : regfile_arb_pkg
`default_nettype wire

// File: rtl/regfile_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : regfile_arb
// Description : Two-requester (write / read) arbiter in front of an external
//               register file. Requests are sampled in IDLE; a tie is broken
//               round-robin (write wins the first tie after reset). A write
//               takes one cycle (WR); a read issues in RD, the register file
//               returns data in CAP and the operands appear on
//               rd_data1/rd_data2 with a one-cycle rd_valid pulse.
//               Every output comes straight from a flop: output values are
//               computed from the next state and registered with it.
//
// Ports       : clk, rst (asynchronous, active-low)
//               wr_req/wr_addr/wr_data -> wr_gnt          write requester
//               rd_req/rd_addr1/rd_addr2 -> rd_gnt,
//                    rd_valid, rd_data1, rd_data2         read requester
//               busy                                       not in IDLE
//               rf_rst, rf_enable, rf_write, rf_src1_addr,
//               rf_src2_addr, rf_write_addr, rf_write_data,
//               rf_src1, rf_src2                           register file side
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_arb
    import regfile_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic              rd_gnt,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              busy,
    output logic              rf_rst,
    output logic              rf_enable,
    output logic              rf_write,
    output logic [ADDR_W-1:0] rf_src1_addr,
    output logic [ADDR_W-1:0] rf_src2_addr,
    output logic [ADDR_W-1:0] rf_write_addr,
    output logic [DATA_W-1:0] rf_write_data,
    input  logic [DATA_W-1:0] rf_src1,
    input  logic [DATA_W-1:0] rf_src2
);

    state_t r_state;
    state_t w_state_next;

    // INIT is held for one full clocked cycle after reset release so that
    // the register file sees rf_rst on a rising edge; r_init_seen marks
    // that this cycle has started.
    logic   r_init_seen;
    logic   w_init_seen_next;

    // Round-robin pointer: 1 = the read requester was granted last.
    logic   r_last_rd;
    logic   w_last_rd_next;

    logic   w_grant_wr;
    logic   w_grant_rd;

    // ------------------------------------------------------------------
    // Next-state / arbitration
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next     = r_state;
        w_init_seen_next = r_init_seen;
        w_last_rd_next   = r_last_rd;
        w_grant_wr       = 1'b0;
        w_grant_rd       = 1'b0;

        case (r_state)
            INIT: begin
                if (r_init_seen) begin
                    w_state_next = IDLE;
                end else begin
                    w_init_seen_next = 1'b1;
                end
            end

            IDLE: begin
                if (wr_req && rd_req) begin
                    // Tie: grant whoever did not win last time.
                    w_grant_wr = r_last_rd;
                    w_grant_rd = ~r_last_rd;
                end else begin
                    w_grant_wr = wr_req;
                    w_grant_rd = rd_req;
                end

                if (w_grant_wr) begin
                    w_state_next   = WR;
                    w_last_rd_next = 1'b0;
                end else if (w_grant_rd) begin
                    w_state_next   = RD;
                    w_last_rd_next = 1'b1;
                end
            end

            WR:  w_state_next = IDLE;
            RD:  w_state_next = CAP;
            CAP: w_state_next = IDLE;

            default: begin
                w_state_next     = INIT;
                w_init_seen_next = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= INIT;
            r_init_seen   <= 1'b0;
            r_last_rd     <= 1'b1;
            rf_rst        <= 1'b1;
            busy          <= 1'b0;
            rf_enable     <= 1'b0;
            rf_write      <= 1'b0;
            wr_gnt        <= 1'b0;
            rd_gnt        <= 1'b0;
            rd_valid      <= 1'b0;
            rd_data1      <= '0;
            rd_data2      <= '0;
            rf_src1_addr  <= '0;
            rf_src2_addr  <= '0;
            rf_write_addr <= '0;
            rf_write_data <= '0;
        end else begin
            r_state     <= w_state_next;
            r_init_seen <= w_init_seen_next;
            r_last_rd   <= w_last_rd_next;

            // Outputs describe the state being entered at this edge.
            rf_rst    <= (w_state_next == INIT);
            busy      <= is_busy(w_state_next);
            rf_enable <= (w_state_next == WR) || (w_state_next == RD);
            rf_write  <= (w_state_next == WR);
            wr_gnt    <= (w_state_next == WR);
            rd_gnt    <= (w_state_next == RD);

            // Operands are captured at the end of CAP, so valid follows it.
            rd_valid  <= (r_state == CAP);

            if (w_grant_wr) begin
                rf_write_addr <= wr_addr;
                rf_write_data <= wr_data;
            end

            if (w_grant_rd) begin
                rf_src1_addr <= rd_addr1;
                rf_src2_addr <= rd_addr2;
            end

            if (r_state == CAP) begin
                rd_data1 <= rf_src1;
                rd_data2 <= rf_src2;
            end
        end
    end

endmodule : regfile_arb
`default_nettype wire

// File: tb/tb_regfile_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_regfile_arb
// Description : Self-checking bench for regfile_arb. Contains a behavioural
//               register file wired as the arbiter's sibling, plus a
//               reference memory image updated from the transactions the
//               bench itself issues.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_arb;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              wr_req = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              wr_gnt;
    logic              rd_req = 1'b0;
    logic [ADDR_W-1:0] rd_addr1 = '0;
    logic [ADDR_W-1:0] rd_addr2 = '0;
    logic              rd_gnt;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic              busy;
    logic              rf_rst;
    logic              rf_enable;
    logic              rf_write;
    logic [ADDR_W-1:0] rf_src1_addr;
    logic [ADDR_W-1:0] rf_src2_addr;
    logic [ADDR_W-1:0] rf_write_addr;
    logic [DATA_W-1:0] rf_write_data;
    logic [DATA_W-1:0] rf_src1;
    logic [DATA_W-1:0] rf_src2;

    int npass  = 0;
    int ntotal = 0;
    int cyc    = 0;

    logic [DATA_W-1:0] model_mem [DEPTH];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    regfile_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
        .rd_req(rd_req), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_gnt(rd_gnt),
        .rd_valid(rd_valid), .rd_data1(rd_data1), .rd_data2(rd_data2),
        .busy(busy), .rf_rst(rf_rst), .rf_enable(rf_enable), .rf_write(rf_write),
        .rf_src1_addr(rf_src1_addr), .rf_src2_addr(rf_src2_addr),
        .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data),
        .rf_src1(rf_src1), .rf_src2(rf_src2)
    );

    // Sibling register file: synchronous clear, write, registered read.
    logic [DATA_W-1:0] rf_mem [DEPTH];
    always @(posedge clk) begin
        if (rf_rst) begin
            for (int i = 0; i < DEPTH; i++) rf_mem[i] <= '0;
        end else if (rf_enable && rf_write) begin
            rf_mem[rf_write_addr] <= rf_write_data;
        end else if (rf_enable) begin
            rf_src1 <= rf_mem[rf_src1_addr];
            rf_src2 <= rf_mem[rf_src2_addr];
        end
    end

    // The register file is touched exactly when a grant is issued, and only
    // a write grant selects write mode.
    always @(negedge clk) begin
        if (rst) begin
            ntotal++;
            if (rf_enable !== (wr_gnt | rd_gnt) || rf_write !== wr_gnt || (wr_gnt & rd_gnt)) begin
                $display("FAIL rf_ctrl t=%0t enable=%b write=%b wr_gnt=%b rd_gnt=%b (required enable=gnt, write=wr_gnt, single grant)",
                         $time, rf_enable, rf_write, wr_gnt, rd_gnt);
            end else begin
                npass++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    endtask

    task automatic do_reset();
        wr_req = 1'b0;
        rd_req = 1'b0;
        rst    = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        tick();
        clear_model();
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                            output int lat);
        int n = 0;
        wr_addr = a;
        wr_data = d;
        wr_req  = 1'b1;
        do begin tick(); n++; end while (!wr_gnt && n < 20);
        wr_req = 1'b0;
        lat    = n;
        ntotal++;
        if (rf_write_addr !== a || rf_write_data !== d) begin
            $display("FAIL wr_operands addr=%0d data=%h required addr=%0d data=%h",
                     rf_write_addr, rf_write_data, a, d);
        end else begin
            npass++;
        end
        if (wr_gnt) model_mem[a] = d;
        tick();
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2,
                           output logic [DATA_W-1:0] d1, output logic [DATA_W-1:0] d2,
                           output int lat_gnt, output int lat_valid);
        int n = 0;
        rd_addr1 = a1;
        rd_addr2 = a2;
        rd_req   = 1'b1;
        do begin tick(); n++; end while (!rd_gnt && n < 20);
        rd_req  = 1'b0;
        lat_gnt = n;
        ntotal++;
        if (rf_src1_addr !== a1 || rf_src2_addr !== a2) begin
            $display("FAIL rd_operands addr1=%0d addr2=%0d required %0d %0d",
                     rf_src1_addr, rf_src2_addr, a1, a2);
        end else begin
            npass++;
        end
        do begin tick(); n++; end while (!rd_valid && n < 40);
        lat_valid = n;
        d1 = rd_data1;
        d2 = rd_data2;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        ntotal++;
        if (rf_rst !== 1'b1 || busy !== 1'b0 || wr_gnt !== 1'b0 || rd_gnt !== 1'b0 ||
            rd_valid !== 1'b0 || rf_enable !== 1'b0 || rd_data1 !== '0 || rd_data2 !== '0) begin
            $display("FAIL reset_hold rf_rst=%b busy=%b gnt=%b%b valid=%b en=%b d1=%h d2=%h required rf_rst=1, rest 0",
                     rf_rst, busy, wr_gnt, rd_gnt, rd_valid, rf_enable, rd_data1, rd_data2);
        end else npass++;
        rst = 1'b1;
        tick();
        ntotal++;
        if (rf_rst !== 1'b1 || busy !== 1'b1 || wr_gnt !== 1'b0 || rd_gnt !== 1'b0 || rd_valid !== 1'b0) begin
            $display("FAIL init_cycle rf_rst=%b busy=%b gnt=%b%b valid=%b required rf_rst=1 busy=1 gnt/valid=0",
                     rf_rst, busy, wr_gnt, rd_gnt, rd_valid);
        end else npass++;
        tick();
        ntotal++;
        if (rf_rst !== 1'b0 || busy !== 1'b0 || wr_gnt !== 1'b0 || rd_gnt !== 1'b0 || rd_valid !== 1'b0) begin
            $display("FAIL idle_after_init rf_rst=%b busy=%b gnt=%b%b valid=%b required all 0",
                     rf_rst, busy, wr_gnt, rd_gnt, rd_valid);
        end else npass++;
        tick();
        ntotal++;
        if (busy !== 1'b0) begin
            $display("FAIL idle_stays busy=%b required 0", busy);
        end else npass++;
        clear_model();
    endtask

    task automatic test_write_read();
        int lw, lg, lv;
        logic [DATA_W-1:0] d1, d2;
        do_write(6'd5, 32'hDEADBEEF, lw);
        ntotal++;
        if (lw !== 1) $display("FAIL wr_latency got=%0d required=1", lw); else npass++;
        do_read(6'd5, 6'd0, d1, d2, lg, lv);
        ntotal++;
        if (lg !== 1 || lv !== 3) $display("FAIL rd_latency gnt=%0d valid=%0d required 1 and 3", lg, lv); else npass++;
        ntotal++;
        if (d1 !== 32'hDEADBEEF || d2 !== 32'h0)
            $display("FAIL raw_data d1=%h d2=%h required deadbeef 00000000", d1, d2);
        else npass++;
    endtask

    task automatic test_arbitration();
        logic [DATA_W-1:0] exp_q [$];
        int g = 0;
        int n = 0;
        do_reset();
        wr_addr  = 6'($urandom_range(0, 7));
        wr_data  = $urandom;
        rd_addr1 = 6'($urandom_range(0, 7));
        rd_addr2 = 6'($urandom_range(0, 7));
        wr_req   = 1'b1;
        rd_req   = 1'b1;
        while (g < 8 && n < 100) begin
            tick();
            n++;
            if (rd_valid && exp_q.size() >= 2) begin
                ntotal++;
                if (rd_data1 !== exp_q[0] || rd_data2 !== exp_q[1])
                    $display("FAIL arb_rd_data d1=%h d2=%h required %h %h", rd_data1, rd_data2, exp_q[0], exp_q[1]);
                else npass++;
                void'(exp_q.pop_front());
                void'(exp_q.pop_front());
            end
            if (wr_gnt || rd_gnt) begin
                ntotal++;
                // Even grants go to the writer, odd grants to the reader.
                if (wr_gnt !== (g % 2 == 0) || rd_gnt !== (g % 2 == 1))
                    $display("FAIL arb_order grant#%0d wr=%b rd=%b required %s", g, wr_gnt, rd_gnt,
                             (g % 2 == 0) ? "W" : "R");
                else npass++;
                if (wr_gnt) begin
                    model_mem[wr_addr] = wr_data;
                    wr_addr = 6'($urandom_range(0, 7));
                    wr_data = $urandom;
                end
                if (rd_gnt) begin
                    exp_q.push_back(model_mem[rd_addr1]);
                    exp_q.push_back(model_mem[rd_addr2]);
                    rd_addr1 = 6'($urandom_range(0, 7));
                    rd_addr2 = 6'($urandom_range(0, 7));
                end
                g++;
            end
        end
        wr_req = 1'b0;
        rd_req = 1'b0;
        n = 0;
        while (exp_q.size() >= 2 && n < 20) begin
            tick();
            n++;
            if (rd_valid) begin
                ntotal++;
                if (rd_data1 !== exp_q[0] || rd_data2 !== exp_q[1])
                    $display("FAIL arb_rd_data d1=%h d2=%h required %h %h", rd_data1, rd_data2, exp_q[0], exp_q[1]);
                else npass++;
                void'(exp_q.pop_front());
                void'(exp_q.pop_front());
            end
        end
        ntotal++;
        if (g !== 8 || exp_q.size() !== 0)
            $display("FAIL arb_timeout grants=%0d pending=%0d required 8 and 0", g, exp_q.size());
        else npass++;
        tick();
    endtask

    task automatic test_back_to_back();
        int lw, v1, v2, n;
        logic held_ok = 1'b1;
        do_write(6'd1, 32'h11, lw);
        do_write(6'd2, 32'h22, lw);
        rd_addr1 = 6'd1;
        rd_addr2 = 6'd2;
        rd_req   = 1'b1;
        n = 0;
        do begin tick(); n++; if (rd_gnt) rd_req = 1'b0; end while (!rd_valid && n < 20);
        rd_req = 1'b0;
        v1 = cyc;
        ntotal++;
        if (rd_data1 !== 32'h11 || rd_data2 !== 32'h22)
            $display("FAIL b2b_first d1=%h d2=%h required 11 22", rd_data1, rd_data2);
        else npass++;
        tick();
        rd_addr1 = 6'd2;
        rd_addr2 = 6'd1;
        rd_req   = 1'b1;
        n = 0;
        do begin
            if (rd_data1 !== 32'h11) held_ok = 1'b0;
            tick();
            n++;
            if (rd_gnt) rd_req = 1'b0;
        end while (!rd_valid && n < 20);
        rd_req = 1'b0;
        v2 = cyc;
        ntotal++;
        if (!held_ok) $display("FAIL b2b_hold rd_data1 changed between pulses required 11"); else npass++;
        ntotal++;
        if (v2 - v1 !== 4) $display("FAIL b2b_gap got=%0d required=4", v2 - v1); else npass++;
        ntotal++;
        if (rd_data1 !== 32'h22 || rd_data2 !== 32'h11)
            $display("FAIL b2b_second d1=%h d2=%h required 22 11", rd_data1, rd_data2);
        else npass++;
    endtask

    task automatic test_random();
        int lw, lg, lv;
        logic [ADDR_W-1:0] a1, a2;
        logic [DATA_W-1:0] d, d1, d2;
        for (int k = 0; k < 24; k++) begin
            a1 = 6'($urandom_range(0, 15));
            a2 = 6'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 0) begin
                d = $urandom;
                do_write(a1, d, lw);
                ntotal++;
                if (lw !== 1) $display("FAIL rnd_wr_latency op=%0d got=%0d required=1", k, lw); else npass++;
            end else begin
                do_read(a1, a2, d1, d2, lg, lv);
                ntotal++;
                if (lg !== 1 || lv !== 3 || d1 !== model_mem[a1] || d2 !== model_mem[a2])
                    $display("FAIL rnd_read op=%0d gnt=%0d valid=%0d d1=%h d2=%h required 1 3 %h %h",
                             k, lg, lv, d1, d2, model_mem[a1], model_mem[a2]);
                else npass++;
            end
        end
    endtask

    task automatic test_reset_cap();
        int lw, lg, lv;
        logic no_valid = 1'b1;
        logic [DATA_W-1:0] d1, d2;
        do_write(6'd9, 32'hCAFE0009, lw);
        rd_addr1 = 6'd9;
        rd_addr2 = 6'd9;
        rd_req   = 1'b1;
        tick();
        ntotal++;
        if (rd_gnt !== 1'b1) $display("FAIL cap_setup rd_gnt=%b required 1", rd_gnt); else npass++;
        rd_req = 1'b0;
        tick();                 // now in CAP
        rst = 1'b0;
        #1;
        ntotal++;
        if (rd_valid !== 1'b0 || rd_data1 !== '0 || rd_data2 !== '0 || rf_rst !== 1'b1 ||
            busy !== 1'b0 || rf_enable !== 1'b0 || rf_src1_addr !== '0 || rf_write_data !== '0)
            $display("FAIL cap_abort valid=%b d1=%h d2=%h rf_rst=%b busy=%b en=%b required 0 0 0 1 0 0",
                     rd_valid, rd_data1, rd_data2, rf_rst, busy, rf_enable);
        else npass++;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (rd_valid !== 1'b0 || rd_gnt !== 1'b0 || wr_gnt !== 1'b0) no_valid = 1'b0;
        end
        rst = 1'b1;
        tick();
        ntotal++;
        if (rf_rst !== 1'b1 || busy !== 1'b1 || rd_valid !== 1'b0)
            $display("FAIL cap_reinit rf_rst=%b busy=%b valid=%b required 1 1 0", rf_rst, busy, rd_valid);
        else npass++;
        if (rd_valid !== 1'b0) no_valid = 1'b0;
        tick();
        if (rd_valid !== 1'b0) no_valid = 1'b0;
        ntotal++;
        if (!no_valid || rf_rst !== 1'b0 || busy !== 1'b0)
            $display("FAIL cap_no_pulse no_valid=%b rf_rst=%b busy=%b required 1 0 0", no_valid, rf_rst, busy);
        else npass++;
        clear_model();
        do_read(6'd9, 6'd0, d1, d2, lg, lv);
        ntotal++;
        if (d1 !== 32'h0 || lv !== 3)
            $display("FAIL cap_cleared d1=%h valid_lat=%0d required 0 and 3", d1, lv);
        else npass++;
    endtask

    initial begin
        clear_model();
        test_reset();
        test_write_read();
        test_arbitration();
        test_back_to_back();
        test_random();
        test_reset_cap();
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule : tb_regfile_arb
`default_nettype wire
